peripheral_interrupt_bank: RTL and testbench

//  Parametrised bank of NUM_REGS peripheral interrupt flag registers (PIRx), each

---
 rtl/peripheral_interrupt_bank_pkg.sv | 22 ++
 rtl/peripheral_interrupt_bank_edge_detect.sv | 28 ++
 rtl/peripheral_interrupt_bank.sv | 110 +++++++++++
 tb/tb_peripheral_interrupt_bank.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_interrupt_bank_pkg.sv
// Package: pic_irq_pkg
// Shared definitions for the peripheral interrupt bank and the core INTCON
// logic: register-select encodings and a lowest-set-bit priority helper.
package pic_irq_pkg;

  localparam logic FLAG_SEL = 1'b0;
  localparam logic EN_SEL   = 1'b1;

  // Widest request vector the priority helper accepts; callers zero-extend.
  localparam int PRIO_MAX_BITS = 1024;

  // Index of the lowest set bit (bit 0 = highest priority); 0 when none set.
  function automatic int lowest_set_idx(input logic [PRIO_MAX_BITS-1:0] v);
    int idx;
    idx = 0;
    for (int i = PRIO_MAX_BITS - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/peripheral_interrupt_bank_edge_detect.sv
// Module: irq_edge_detect
// Per-bit event qualifier for peripheral interrupt sources. Bits marked in
// EDGE_MASK fire only on a 0->1 transition; the rest pass the level through.
// Ports:
//   clk, rst  clock, synchronous active-high reset (clears the source history)
//   src       raw peripheral source bits
//   ev        qualified event bits, combinational in the sampling cycle
module irq_edge_detect #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  EDGE_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] src,
  output logic [WIDTH-1:0] ev
);

  // History starts at 0 so a source already high at reset release yields one edge.
  logic [WIDTH-1:0] src_prev;

  always_ff @(posedge clk) begin
    if (rst) src_prev <= '0;
    else     src_prev <= src;
  end

  assign ev = src & ~(EDGE_MASK & src_prev);

endmodule

// File: rtl/peripheral_interrupt_bank.sv
// Module: peripheral_interrupt_bank
// Bank of NUM_REGS interrupt flag registers, each paired with an enable
// register. Flags are set by peripheral events (level or rising edge) and
// written by software; events win over a same-cycle write. Produces a
// registered aggregate request and a registered lowest-index pending bit.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   addr        register pair select (out-of-range: writes ignored, reads 0)
//   sel_en      0 = flag register, 1 = enable register
//   wr_en, d    write strobe and data for the selected register
//   rd_q        combinational read of the selected register (pre-update)
//   irq_src     peripheral sources; bit r*WIDTH+b feeds register r bit b
//   flags_q     all flag registers concatenated
//   enables_q   all enable registers concatenated
//   irq         registered OR of flags & enables
//   pend_valid  registered copy of irq
//   pend_idx    registered lowest set index of flags & enables (held when idle)
module peripheral_interrupt_bank
  import pic_irq_pkg::*;
#(
  parameter int                         WIDTH      = 8,
  parameter int                         NUM_REGS   = 2,
  parameter logic [NUM_REGS*WIDTH-1:0]  FLAG_RESET = '0,
  parameter logic [NUM_REGS*WIDTH-1:0]  EN_RESET   = '0,
  parameter logic [NUM_REGS*WIDTH-1:0]  EDGE_MASK  = '0,
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int IW = (NUM_REGS * WIDTH > 1) ? $clog2(NUM_REGS * WIDTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AW-1:0]             addr,
  input  logic                      sel_en,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          d,
  output logic [WIDTH-1:0]          rd_q,
  input  logic [NUM_REGS*WIDTH-1:0] irq_src,
  output logic [NUM_REGS*WIDTH-1:0] flags_q,
  output logic [NUM_REGS*WIDTH-1:0] enables_q,
  output logic                      irq,
  output logic                      pend_valid,
  output logic [IW-1:0]             pend_idx
);

  localparam int TOT = NUM_REGS * WIDTH;

  logic [TOT-1:0] ev;
  logic [TOT-1:0] flag_next;
  logic [TOT-1:0] en_next;
  logic [TOT-1:0] act_p0;

  irq_edge_detect #(
    .WIDTH     (TOT),
    .EDGE_MASK (EDGE_MASK)
  ) u_edge (
    .clk (clk),
    .rst (rst),
    .src (irq_src),
    .ev  (ev)
  );

  // Software write first, then OR in events so an event always survives a clear.
  always_comb begin
    flag_next = flags_q;
    en_next   = enables_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (wr_en && (addr == AW'(r))) begin
        if (sel_en == FLAG_SEL) flag_next[r*WIDTH +: WIDTH] = d;
        else                    en_next[r*WIDTH +: WIDTH]   = d;
      end
    end
    flag_next = flag_next | ev;
  end

  always_comb begin
    rd_q = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (addr == AW'(r)) begin
        rd_q = (sel_en == EN_SEL) ? enables_q[r*WIDTH +: WIDTH]
                                  : flags_q[r*WIDTH +: WIDTH];
      end
    end
  end

  // ---- stage p0: flag / enable register file ----
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q   <= FLAG_RESET;
      enables_q <= EN_RESET;
    end else begin
      flags_q   <= flag_next;
      enables_q <= en_next;
    end
  end

  assign act_p0 = flags_q & enables_q;

  // ---- stage p1: registered request and priority index ----
  always_ff @(posedge clk) begin
    if (rst) begin
      irq        <= 1'b0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
    end else begin
      irq        <= |act_p0;
      pend_valid <= |act_p0;
      if (|act_p0) pend_idx <= IW'(lowest_set_idx(PRIO_MAX_BITS'(act_p0)));
    end
  end

endmodule

// File: tb/tb_peripheral_interrupt_bank.sv
module tb_peripheral_interrupt_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // DUT A: 2 registers, FLAG_RESET=1, bit 3 edge-triggered
  logic        a_addr, a_sel, a_wr;
  logic [7:0]  a_d, a_rd;
  logic [15:0] a_src, a_flags, a_en;
  logic        a_irq, a_pv;
  logic [3:0]  a_idx;
  // DUT B: 3 registers, bit 3 edge-triggered
  logic [1:0]  b_addr;
  logic        b_sel, b_wr;
  logic [7:0]  b_d, b_rd;
  logic [23:0] b_src, b_flags, b_en;
  logic        b_irq, b_pv;
  logic [4:0]  b_idx;

  peripheral_interrupt_bank #(
    .WIDTH(8), .NUM_REGS(2), .FLAG_RESET(16'h0001), .EN_RESET(16'h0000),
    .EDGE_MASK(16'h0008)
  ) dut_a (
    .clk(clk), .rst(rst), .addr(a_addr), .sel_en(a_sel), .wr_en(a_wr), .d(a_d),
    .rd_q(a_rd), .irq_src(a_src), .flags_q(a_flags), .enables_q(a_en),
    .irq(a_irq), .pend_valid(a_pv), .pend_idx(a_idx)
  );

  peripheral_interrupt_bank #(
    .WIDTH(8), .NUM_REGS(3), .FLAG_RESET(24'h000000), .EN_RESET(24'h000000),
    .EDGE_MASK(24'h000008)
  ) dut_b (
    .clk(clk), .rst(rst), .addr(b_addr), .sel_en(b_sel), .wr_en(b_wr), .d(b_d),
    .rd_q(b_rd), .irq_src(b_src), .flags_q(b_flags), .enables_q(b_en),
    .irq(b_irq), .pend_valid(b_pv), .pend_idx(b_idx)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (bit-level, per DUT k) ----------------
  logic [23:0] mf [2];
  logic [23:0] me [2];
  logic [23:0] mp [2];
  logic        mirq [2];
  int          midx [2];
  logic        model_ok = 1'b0;

  function automatic int nbits(input int k);
    return (k == 0) ? 16 : 24;
  endfunction

  function automatic logic [7:0] model_rd(input int k, input int a, input logic s);
    if (a >= nbits(k) / 8) return 8'h00;
    return s ? me[k][a*8 +: 8] : mf[k][a*8 +: 8];
  endfunction

  task automatic model_step(input int k, input logic r, input int a, input logic s,
                            input logic w, input logic [7:0] dd, input logic [23:0] src,
                            output logic [23:0] nf, output logic [23:0] ne,
                            output logic [23:0] np, output logic nirq, output int nidx);
    int n;
    int low;
    n = nbits(k);
    if (r) begin
      nf = (k == 0) ? 24'h000001 : 24'h000000;
      ne = 24'h0; np = 24'h0; nirq = 1'b0; nidx = 0;
      return;
    end
    nf = mf[k]; ne = me[k]; nidx = midx[k];
    low = -1;
    for (int i = 0; i < n; i++)
      if (mf[k][i] && me[k][i] && low < 0) low = i;
    nirq = (low >= 0);
    if (low >= 0) nidx = low;
    if (w && a < n / 8)
      for (int b = 0; b < 8; b++)
        if (s) ne[a*8 + b] = dd[b]; else nf[a*8 + b] = dd[b];
    for (int i = 0; i < n; i++)
      if (src[i] && (i != 3 || !mp[k][i])) nf[i] = 1'b1;
    np = 24'h0;
    for (int i = 0; i < n; i++) np[i] = src[i];
  endtask

  always @(posedge clk) begin
    logic [23:0] f0, e0, p0, f1, e1, p1;
    logic        q0, q1;
    int          x0, x1;
    model_step(0, rst, int'(a_addr), a_sel, a_wr, a_d, {8'h00, a_src}, f0, e0, p0, q0, x0);
    model_step(1, rst, int'(b_addr), b_sel, b_wr, b_d, b_src, f1, e1, p1, q1, x1);
    mf[0] <= f0; me[0] <= e0; mp[0] <= p0; mirq[0] <= q0; midx[0] <= x0;
    mf[1] <= f1; me[1] <= e1; mp[1] <= p1; mirq[1] <= q1; midx[1] <= x1;
    if (rst) model_ok <= 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      chk("a_flags", 24'(a_flags), mf[0]);
      chk("a_en",    24'(a_en),    me[0]);
      chk("a_irq",   24'(a_irq),   24'(mirq[0]));
      chk("a_pv",    24'(a_pv),    24'(mirq[0]));
      chk("a_idx",   24'(a_idx),   24'(midx[0]));
      chk("a_rd",    24'(a_rd),    24'(model_rd(0, int'(a_addr), a_sel)));
      chk("b_flags", b_flags,      mf[1]);
      chk("b_en",    b_en,         me[1]);
      chk("b_irq",   24'(b_irq),   24'(mirq[1]));
      chk("b_pv",    24'(b_pv),    24'(mirq[1]));
      chk("b_idx",   24'(b_idx),   24'(midx[1]));
      chk("b_rd",    24'(b_rd),    24'(model_rd(1, int'(b_addr), b_sel)));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wa(input logic ad, input logic s, input logic [7:0] dv);
    a_addr = ad; a_sel = s; a_d = dv; a_wr = 1'b1;
    cyc(1);
    a_wr = 1'b0;
  endtask

  task automatic wb(input logic [1:0] ad, input logic s, input logic [7:0] dv);
    b_addr = ad; b_sel = s; b_d = dv; b_wr = 1'b1;
    cyc(1);
    b_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_addr = 1'b0; a_sel = 1'b0; a_wr = 1'b0; a_d = 8'h00; a_src = 16'h0000;
    b_addr = 2'd0; b_sel = 1'b0; b_wr = 1'b0; b_d = 8'h00; b_src = 24'h000000;
    cyc(2);
    rst = 1'b0;

    // 1 reset values
    chk("t1_flags", 24'(a_flags), 24'h000001);
    chk("t1_irq",   24'(a_irq),   24'h0);
    chk("t1_rd",    24'(a_rd),    24'h01);

    // 2 level event on MSB of reg 0
    wa(1'b0, 1'b1, 8'h80);
    a_src = 16'h0080;
    cyc(1);
    a_src = 16'h0000;
    chk("t2_flag7", 24'(a_flags[7]), 24'h1);
    chk("t2_irq_early", 24'(a_irq), 24'h0);
    cyc(1);
    chk("t2_irq", 24'(a_irq), 24'h1);
    chk("t2_idx", 24'(a_idx), 24'd7);

    // 3 event beats a same-cycle clear
    wa(1'b1, 1'b0, 8'hFF);
    a_src = 16'h0200;
    wa(1'b1, 1'b0, 8'h00);
    a_src = 16'h0000;
    chk("t3_reg1", 24'(a_flags[15:8]), 24'h02);

    // 4 edge source held high, cleared mid-way
    wa(1'b0, 1'b0, 8'h00);
    a_src = 16'h0008;
    cyc(1);
    chk("t4_set", 24'(a_flags[3]), 24'h1);
    cyc(1);
    wa(1'b0, 1'b0, 8'h00);
    cyc(2);
    chk("t4_stay0", 24'(a_flags[3]), 24'h0);
    a_src = 16'h0000;
    cyc(1);
    a_src = 16'h0008;
    cyc(1);
    chk("t4_reedge", 24'(a_flags[3]), 24'h1);
    a_src = 16'h0000;

    // 5 priority encoding
    wa(1'b0, 1'b0, 8'h04);
    wa(1'b1, 1'b0, 8'h81);
    wa(1'b0, 1'b1, 8'hFF);
    wa(1'b1, 1'b1, 8'hFF);
    cyc(1);
    chk("t5_idx2", 24'(a_idx), 24'd2);
    wa(1'b0, 1'b0, 8'h00);
    cyc(1);
    chk("t5_idx8", 24'(a_idx), 24'd8);
    wa(1'b0, 1'b0, 8'h80);
    cyc(1);
    chk("t5_idx7", 24'(a_idx), 24'd7);
    wa(1'b1, 1'b1, 8'h00);
    cyc(1);
    chk("t5_irq_r1off", 24'(a_irq), 24'h1);
    chk("t5_idx_r1off", 24'(a_idx), 24'd7);
    wa(1'b0, 1'b1, 8'h7F);
    cyc(1);
    chk("t5_irq_off", 24'(a_irq), 24'h0);
    chk("t5_idx_hold", 24'(a_idx), 24'd7);

    // simultaneous events all latch
    wa(1'b0, 1'b0, 8'h00);
    wa(1'b1, 1'b0, 8'h00);
    a_src = 16'h5A5A;
    cyc(1);
    a_src = 16'h0000;
    chk("t5_multi", 24'(a_flags), 24'h005A5A);

    // 6 out-of-range address on the 3-register bank, then reset mid-burst
    wb(2'd2, 1'b0, 8'h3C);
    b_addr = 2'd3; b_sel = 1'b0;
    #1;
    chk("t6_rd_oor", 24'(b_rd), 24'h00);
    wb(2'd3, 1'b0, 8'hFF);
    wb(2'd3, 1'b1, 8'hFF);
    chk("t6_flags", b_flags, 24'h3C0000);
    chk("t6_en",    b_en,    24'h000000);
    chk("t6_rd",    24'(b_rd), 24'h00);
    wb(2'd0, 1'b1, 8'hFF);
    b_src = 24'hFFFFFF;
    a_src = 16'hFFFF;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t6_rst_flags", b_flags, 24'h000000);
    chk("t6_rst_en",    b_en,    24'h000000);
    chk("t6_rst_irq",   24'(b_irq), 24'h0);
    chk("t6_rst_idx",   24'(b_idx), 24'h0);
    chk("t6_rst_aflags", 24'(a_flags), 24'h000001);
    cyc(1);
    chk("t6_post_rst_ev", b_flags, 24'hFFFFFF);
    cyc(2);
    b_src = 24'h000000;
    a_src = 16'h0000;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
